// File: rtl/spi_shift_clock_ctrl_pkg.sv
// Shared types for the SPI shift-clock controller.
// Control bundle from the register block and FSM state encoding.
package spi_shift_clock_ctrl_pkg;

    localparam int SPI_DATALEN_W = 5;
    localparam int SPI_BR_W      = 8;

    typedef struct packed {
        logic                     mclk_sel;
        logic                     cpol;
        logic                     mstr;
        logic                     cpha;
        logic [SPI_DATALEN_W-1:0] datalen;
        logic [SPI_BR_W-1:0]      spi_br;
        logic                     transfer_start;
    } sc2scc_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        CMPL_WAIT
    } scc_state_e;

endpackage

// File: rtl/spi_shift_clock_ctrl_baud.sv
// Baud divider: one-cycle tick every H pclk while enabled.
// H = spi_br+1, or (spi_br+1)*4 when mclk_sel is set.
module spi_baud_divider
    import spi_shift_clock_ctrl_pkg::*;
#(
    parameter int BR_W = SPI_BR_W
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic            clr,
    input  logic            en,
    input  logic [BR_W-1:0] spi_br,
    input  logic            mclk_sel,
    output logic            tick
);

    localparam logic [BR_W+1:0] ONE = 1;

    logic [BR_W+1:0] cnt;
    logic [BR_W+1:0] lim;

    // Terminal count is H-1; the x4 prescale is a 2-bit shift with ones fill.
    always_comb begin
        lim  = mclk_sel ? {spi_br, 2'b11} : {2'b00, spi_br};
        tick = en && (cnt == lim);
    end

    // Free-running count while enabled, wrapping at the terminal count.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/spi_shift_clock_ctrl.sv
// SPI bit-clock engine: generates or tracks SCK and issues
// load/shift/sample strobes to the data shifter.
module spi_shift_clock_ctrl
    import spi_shift_clock_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATALEN_W   = SPI_DATALEN_W,
    parameter int BR_W        = SPI_BR_W
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  sc2scc_t              sc2scc_control,
    input  logic                 swr,
    output logic                 transfer_start_ack,
    output logic                 transfer_complete,
    input  logic                 transfer_complete_ack,
    input  logic                 sck_in,
    output logic                 sck_out,
    output logic                 sck_oe,
    output logic                 load_en,
    output logic                 shift_en,
    output logic                 sample_en,
    output logic [DATALEN_W-1:0] bit_cnt,
    output logic                 busy
);

    localparam logic [DATALEN_W:0]   E_ONE = 1;
    localparam logic [DATALEN_W-1:0] B_ONE = 1;

    scc_state_e state;
    scc_state_e next_state;

    logic                 c_sel;
    logic                 c_mstr;
    logic                 c_cpha;
    logic [DATALEN_W-1:0] c_dl;
    logic [BR_W-1:0]      c_br;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic [DATALEN_W:0]     edge_cnt;
    logic                   fin;
    logic                   tick;
    logic                   start_take;
    logic                   ev;
    logic                   last_edge;
    logic                   do_shift;
    logic                   do_sample;

    spi_baud_divider #(.BR_W(BR_W)) u_div (
        .pclk     (pclk),
        .preset   (preset),
        .clr      (swr || (state != RUN)),
        .en       ((state == RUN) && c_mstr && !fin),
        .spi_br   (c_br),
        .mclk_sel (c_sel),
        .tick     (tick)
    );

    assign busy              = (state != IDLE);
    assign transfer_complete = (state == DONE);
    assign sck_oe            = c_mstr && busy;

    // Edge event and strobe decode from the index of the edge in flight.
    always_comb begin
        start_take = (state == IDLE) && sc2scc_control.transfer_start
                     && !transfer_start_ack;
        ev        = (state == RUN) && !fin
                    && (c_mstr ? tick : (sync[SYNC_STAGES-1] ^ sync_prev));
        last_edge = (edge_cnt == {c_dl, 1'b1});
        do_sample = ev && (edge_cnt[0] == c_cpha);
        do_shift  = ev && (edge_cnt[0] != c_cpha)
                    && !(!c_cpha && last_edge)
                    && !(c_cpha && (edge_cnt == '0));
    end

    // Next-state logic; soft reset overrides everything.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (start_take) next_state = RUN;
            RUN:       if (fin) next_state = DONE;
            DONE:      if (transfer_complete_ack) next_state = CMPL_WAIT;
            CMPL_WAIT: if (!transfer_complete_ack) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (swr) next_state = IDLE;
    end

    // State register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= next_state;
    end

    // External SCK synchroniser plus previous-value flop for edge detect.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], sck_in};
            sync_prev <= sync[SYNC_STAGES-1];
        end
    end

    // Config latch, SCK, edge/bit counters, strobes and start ack.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            c_sel              <= 1'b0;
            c_mstr             <= 1'b0;
            c_cpha             <= 1'b0;
            c_dl               <= '0;
            c_br               <= '0;
            sck_out            <= 1'b0;
            edge_cnt           <= '0;
            bit_cnt            <= '0;
            fin                <= 1'b0;
            load_en            <= 1'b0;
            shift_en           <= 1'b0;
            sample_en          <= 1'b0;
            transfer_start_ack <= 1'b0;
        end else if (swr) begin
            c_sel              <= 1'b0;
            c_mstr             <= 1'b0;
            c_cpha             <= 1'b0;
            c_dl               <= '0;
            c_br               <= '0;
            sck_out            <= sc2scc_control.cpol;
            edge_cnt           <= '0;
            bit_cnt            <= '0;
            fin                <= 1'b0;
            load_en            <= 1'b0;
            shift_en           <= 1'b0;
            sample_en          <= 1'b0;
            transfer_start_ack <= 1'b0;
        end else begin
            load_en   <= start_take;
            shift_en  <= do_shift;
            sample_en <= do_sample;
            if (start_take) begin
                transfer_start_ack <= 1'b1;
            end else if (!sc2scc_control.transfer_start) begin
                transfer_start_ack <= 1'b0;
            end
            if (start_take) begin
                c_sel    <= sc2scc_control.mclk_sel;
                c_mstr   <= sc2scc_control.mstr;
                c_cpha   <= sc2scc_control.cpha;
                c_dl     <= sc2scc_control.datalen;
                c_br     <= sc2scc_control.spi_br;
                sck_out  <= sc2scc_control.cpol;
                edge_cnt <= '0;
                bit_cnt  <= '0;
                fin      <= 1'b0;
            end else if (state == IDLE) begin
                sck_out <= sc2scc_control.cpol;
            end else if (ev) begin
                if (c_mstr) sck_out <= ~sck_out;
                if (last_edge) fin <= 1'b1;
                else           edge_cnt <= edge_cnt + E_ONE;
                if (do_shift)  bit_cnt <= bit_cnt + B_ONE;
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_clock_ctrl.sv
// Scoreboard bench for spi_shift_clock_ctrl: expected strobe events
// are queued per frame and matched by a negedge monitor.
module tb_spi_shift_clock_ctrl;
    import spi_shift_clock_ctrl_pkg::*;

    typedef struct {
        int   kind;
        int   bc;
        logic sck;
        int   gap;
    } ev_t;

    logic       pclk = 1'b0;
    logic       preset;
    sc2scc_t    ctl;
    logic       swr;
    logic       tca;
    logic       sck_in;
    logic       start_ack;
    logic       cmpl;
    logic       sck_out;
    logic       sck_oe;
    logic       load_en;
    logic       shift_en;
    logic       sample_en;
    logic [4:0] bit_cnt;
    logic       busy;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  last_cyc = 0;
    logic cprev = 1'b0;
    ev_t exp_q[$];

    always #5 pclk = ~pclk;

    spi_shift_clock_ctrl dut (
        .pclk                  (pclk),
        .preset                (preset),
        .sc2scc_control        (ctl),
        .swr                   (swr),
        .transfer_start_ack    (start_ack),
        .transfer_complete     (cmpl),
        .transfer_complete_ack (tca),
        .sck_in                (sck_in),
        .sck_out               (sck_out),
        .sck_oe                (sck_oe),
        .load_en               (load_en),
        .shift_en              (shift_en),
        .sample_en             (sample_en),
        .bit_cnt               (bit_cnt),
        .busy                  (busy)
    );

    // Monitor: every strobe or rising complete pops one expected event.
    always @(negedge pclk) begin : mon
        int  k;
        int  gap;
        ev_t e;
        cyc++;
        if (preset) begin
            cprev    = 1'b0;
            last_cyc = cyc;
        end else begin
            k = -1;
            if (int'(load_en) + int'(shift_en) + int'(sample_en) > 1) k = 9;
            else if (load_en)               k = 0;
            else if (shift_en)              k = 1;
            else if (sample_en)             k = 2;
            else if (cmpl && !cprev)        k = 3;
            cprev = cmpl;
            if (k >= 0) begin
                gap      = cyc - last_cyc;
                last_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event kind=%0d bc=%0d at cyc %0d",
                             k, bit_cnt, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (k != e.kind || int'(bit_cnt) != e.bc || sck_out !== e.sck
                        || (e.gap != 0 && gap != e.gap)) begin
                        bad++;
                        $display("FAIL event got kind=%0d bc=%0d sck=%0b gap=%0d want kind=%0d bc=%0d sck=%0b gap=%0d",
                                 k, bit_cnt, sck_out, gap, e.kind, e.bc, e.sck, e.gap);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Queue expected events: kind 0 load, 1 shift, 2 sample, 3 complete.
    task automatic push_frame(input logic cpol, input logic cpha,
                              input logic mstr, input int dl, input int h,
                              input int nedges, input bit with_cmpl);
        int   acc;
        bit   first;
        int   k;
        int   bc;
        logic s;
        acc   = 0;
        first = 1'b1;
        exp_q.push_back('{0, 0, cpol, 0});
        for (int e = 0; e < nedges; e++) begin
            acc += h;
            k  = -1;
            bc = 0;
            if (!cpha) begin
                if (e % 2 == 0) begin k = 2; bc = e / 2; end
                else if (e != 2 * dl + 1) begin k = 1; bc = (e + 1) / 2; end
            end else begin
                if (e % 2 == 1) begin k = 2; bc = (e - 1) / 2; end
                else if (e != 0) begin k = 1; bc = e / 2; end
            end
            s = (mstr && (e % 2 == 0)) ? ~cpol : cpol;
            if (k >= 0) begin
                exp_q.push_back('{k, bc, s, (first && !mstr) ? 0 : acc});
                acc   = 0;
                first = 1'b0;
            end
        end
        if (with_cmpl) exp_q.push_back('{3, dl, cpol, acc + 1});
    endtask

    task automatic start_frame(input logic sel, input logic cpol,
                               input logic mstr, input logic cpha,
                               input int dl, input int br);
        int n;
        @(negedge pclk);
        ctl.mclk_sel       = sel;
        ctl.cpol           = cpol;
        ctl.mstr           = mstr;
        ctl.cpha           = cpha;
        ctl.datalen        = dl[4:0];
        ctl.spi_br         = br[7:0];
        ctl.transfer_start = 1'b1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!start_ack && n < 50);
        chk("start_ack", int'(start_ack), 1);
        ctl.transfer_start = 1'b0;
    endtask

    task automatic finish_frame(input int limit);
        int n;
        n = 0;
        while (!cmpl && n < limit) begin
            @(negedge pclk);
            n++;
        end
        chk("complete_seen", int'(cmpl), 1);
        tca = 1'b1;
        @(negedge pclk);
        chk("complete_drop", int'(cmpl), 0);
        tca = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("back_idle", int'(busy), 0);
    endtask

    initial begin : stim
        int n;
        preset = 1'b1;
        ctl    = '0;
        swr    = 1'b0;
        tca    = 1'b0;
        sck_in = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("reset_outs",
            int'({busy, sck_out, sck_oe, start_ack, cmpl,
                  load_en, shift_en, sample_en, bit_cnt}), 0);

        // Mode 0, br=0, 8 bits.
        push_frame(1'b0, 1'b0, 1'b1, 7, 1, 16, 1'b1);
        start_frame(1'b0, 1'b0, 1'b1, 1'b0, 7, 0);
        chk("sck_oe_master", int'(sck_oe), 1);
        finish_frame(200);

        // Mode 3, br=3, 16 bits.
        @(negedge pclk);
        ctl.cpol = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        chk("sck_idle_cpol1", int'(sck_out), 1);
        push_frame(1'b1, 1'b1, 1'b1, 15, 4, 32, 1'b1);
        start_frame(1'b0, 1'b1, 1'b1, 1'b1, 15, 3);
        finish_frame(500);
        chk("sck_final_cpol1", int'(sck_out), 1);

        // Handshake: long start, late complete ack, start held off in CMPL_WAIT.
        push_frame(1'b0, 1'b0, 1'b1, 7, 1, 16, 1'b1);
        push_frame(1'b0, 1'b0, 1'b1, 7, 1, 16, 1'b1);
        @(negedge pclk);
        ctl                = '0;
        ctl.mstr           = 1'b1;
        ctl.datalen        = 5'd7;
        ctl.transfer_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            chk("ack_held", int'(start_ack), 1);
        end
        ctl.transfer_start = 1'b0;
        @(negedge pclk);
        chk("ack_drop", int'(start_ack), 0);
        n = 0;
        while (!cmpl && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("hs_complete", int'(cmpl), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("cmpl_hold", int'(cmpl), 1);
        end
        tca = 1'b1;
        @(negedge pclk);
        chk("cmpl_wait_state", int'({busy, cmpl}), 2);
        ctl.transfer_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("start_held_off", int'({busy, start_ack, load_en}), 4);
        end
        tca = 1'b0;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!start_ack && n < 20);
        chk("late_start_taken", int'(start_ack), 1);
        ctl.transfer_start = 1'b0;
        finish_frame(200);

        // Soft reset in the middle of a frame, then a clean frame.
        push_frame(1'b0, 1'b0, 1'b1, 7, 1, 5, 1'b0);
        start_frame(1'b0, 1'b0, 1'b1, 1'b0, 7, 0);
        repeat (5) @(negedge pclk);
        swr = 1'b1;
        @(negedge pclk);
        swr = 1'b0;
        chk("swr_clear",
            int'({busy, sck_out, cmpl, load_en, shift_en, sample_en, bit_cnt}), 0);
        repeat (20) @(negedge pclk);
        chk("swr_no_complete", int'({busy, cmpl}), 0);
        push_frame(1'b0, 1'b0, 1'b1, 7, 1, 16, 1'b1);
        start_frame(1'b0, 1'b0, 1'b1, 1'b0, 7, 0);
        finish_frame(200);

        // Longest frame, slowest clock: H = 1024.
        push_frame(1'b0, 1'b0, 1'b1, 31, 1024, 64, 1'b1);
        start_frame(1'b1, 1'b0, 1'b1, 1'b0, 31, 255);
        finish_frame(70000);

        // Slave mode, sck_in at pclk/6, edges off the pclk grid.
        push_frame(1'b0, 1'b0, 1'b0, 7, 3, 16, 1'b1);
        start_frame(1'b0, 1'b0, 1'b0, 1'b0, 7, 0);
        #3;
        for (int i = 0; i < 16; i++) begin
            #30 sck_in = ~sck_in;
            if (i == 7) chk("slave_sck_oe", int'(sck_oe), 0);
        end
        finish_frame(100);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
